// File: rtl/matrix_pkg.sv
// Shared types and width constants for the matrix operand loader.
// Defaults mirror the accelerator's definitions.h build configuration.
package matrix_pkg;

  localparam int unsigned DefBitLength      = 8;
  localparam int unsigned DefInputPortCount = 4;
  localparam int unsigned DefAddressLength  = 4;
  localparam int unsigned DefIssueGap       = 4;

  // One lane carries a double-width product operand.
  function automatic int unsigned lane_width(input int unsigned bit_length);
    return 2 * bit_length;
  endfunction

  localparam int unsigned DefLaneW = lane_width(DefBitLength);
  localparam int unsigned DefRowW  = DefInputPortCount * DefLaneW;
  localparam int unsigned DefRowsW = DefAddressLength + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFillA,
    StFillB,
    StIssue,
    StGap,
    StRead,
    StDone
  } loader_state_e;

endpackage

// File: rtl/operand_row_packer.sv
// Packs a serial lane stream into one flat operand row register.
// Lanes fill low to high; row_full flags the beat that writes the last lane.
module operand_row_packer
  import matrix_pkg::*;
#(
  parameter int unsigned LANES  = DefInputPortCount,
  parameter int unsigned LANE_W = DefLaneW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    valid,
  input  logic [LANE_W-1:0]       data,
  output logic [LANES*LANE_W-1:0] row,
  output logic                    row_full
);

  localparam int unsigned LaneCntW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LaneCntW-1:0] LastLane = LaneCntW'(LANES - 1);

  logic [LaneCntW-1:0]     lane_q, lane_d;
  logic [LANES*LANE_W-1:0] row_q, row_d;
  logic                    beat;

  always_comb begin
    beat     = load & valid;
    row_full = beat && (lane_q == LastLane);
    lane_d   = lane_q;
    row_d    = row_q;
    if (beat) begin
      lane_d = row_full ? '0 : lane_q + LaneCntW'(1);
      for (int k = 0; k < int'(LANES); k++) begin
        if (lane_q == LaneCntW'(k)) row_d[k*LANE_W +: LANE_W] = data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      row_q  <= '0;
    end else begin
      lane_q <= lane_d;
      row_q  <= row_d;
    end
  end

  assign row = row_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Row-by-row operand feeder for the matrix accelerator: fills both operand buses,
// issues each row with mStart, then walks the result buffer with bufferRD.
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int unsigned BIT_LENGTH       = DefBitLength,
  parameter int unsigned INPUT_PORT_COUNT = DefInputPortCount,
  parameter int unsigned ADDRESS_LENGTH   = DefAddressLength,
  parameter int unsigned ISSUE_GAP        = DefIssueGap,
  localparam int unsigned LaneW = lane_width(BIT_LENGTH),
  localparam int unsigned RowW  = INPUT_PORT_COUNT * LaneW
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDRESS_LENGTH:0]   cmd_rows,
  input  logic                      cmd_add,
  input  logic                      cmd_direct,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LaneW-1:0]          s_data,
  output logic [RowW-1:0]           multiplier_input,
  output logic [RowW-1:0]           multiplicand_input,
  output logic [ADDRESS_LENGTH-1:0] AddressSelect,
  output logic                      mStart,
  output logic                      bufferRD,
  output logic                      Add,
  output logic                      direct,
  output logic                      done
);

  localparam int unsigned RowsW = ADDRESS_LENGTH + 1;
  localparam int unsigned GapW  = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [RowsW-1:0] MaxRows = RowsW'(2 ** ADDRESS_LENGTH);
  localparam logic [GapW-1:0]  GapLast = GapW'((ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0);

  loader_state_e state_q, state_d;

  logic [RowsW-1:0]          rows_q, rows_d;
  logic [RowsW-1:0]          row_q, row_d, row_inc;
  logic [RowsW-1:0]          rd_q, rd_d;
  logic [GapW-1:0]           gap_q, gap_d;
  logic                      add_q, add_d;
  logic                      direct_q, direct_d;
  logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
  logic                      mstart_q, bufrd_q, done_q;
  logic                      full_a, full_b, advance_row;
  logic                      fill_a, fill_b;

  assign fill_a    = (state_q == StFillA);
  assign fill_b    = (state_q == StFillB);
  assign cmd_ready = (state_q == StIdle);
  assign s_ready   = fill_a | fill_b;

  operand_row_packer #(
    .LANES  (INPUT_PORT_COUNT),
    .LANE_W (LaneW)
  ) u_pack_mult (
    .clk      (Clk),
    .rst      (Rst),
    .load     (fill_a),
    .valid    (s_valid),
    .data     (s_data),
    .row      (multiplier_input),
    .row_full (full_a)
  );

  operand_row_packer #(
    .LANES  (INPUT_PORT_COUNT),
    .LANE_W (LaneW)
  ) u_pack_mcand (
    .clk      (Clk),
    .rst      (Rst),
    .load     (fill_b),
    .valid    (s_valid),
    .data     (s_data),
    .row      (multiplicand_input),
    .row_full (full_b)
  );

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    row_d       = row_q;
    rd_d        = '0;
    gap_d       = '0;
    add_d       = add_q;
    direct_d    = direct_q;
    advance_row = 1'b0;
    row_inc     = row_q + RowsW'(1);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          rows_d   = (cmd_rows > MaxRows) ? MaxRows : cmd_rows;
          add_d    = cmd_add;
          direct_d = cmd_direct;
          row_d    = '0;
          state_d  = (cmd_rows == '0) ? StDone : StFillA;
        end
      end
      StFillA: if (full_a) state_d = StFillB;
      StFillB: if (full_b) state_d = StIssue;
      StIssue: begin
        if (ISSUE_GAP > 1) state_d = StGap;
        else advance_row = 1'b1;
      end
      StGap: begin
        if (gap_q == GapLast) advance_row = 1'b1;
        else gap_d = gap_q + GapW'(1);
      end
      StRead: begin
        rd_d = rd_q + RowsW'(1);
        if (rd_q == rows_q - RowsW'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Row count is one bit wider than the address, so the end compare never aliases.
    if (advance_row) begin
      row_d   = row_inc;
      state_d = (row_inc == rows_q) ? StRead : StFillA;
    end

    addr_d = addr_q;
    if (state_d == StIssue) addr_d = row_q[ADDRESS_LENGTH-1:0];
    else if (state_d == StRead) addr_d = rd_d[ADDRESS_LENGTH-1:0];
  end

  // Strobes and address are registered from next-state so outputs line up with the state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= StIdle;
      rows_q   <= '0;
      row_q    <= '0;
      rd_q     <= '0;
      gap_q    <= '0;
      add_q    <= 1'b0;
      direct_q <= 1'b0;
      addr_q   <= '0;
      mstart_q <= 1'b0;
      bufrd_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      row_q    <= row_d;
      rd_q     <= rd_d;
      gap_q    <= gap_d;
      add_q    <= add_d;
      direct_q <= direct_d;
      addr_q   <= addr_d;
      mstart_q <= (state_d == StIssue);
      bufrd_q  <= (state_d == StRead);
      done_q   <= (state_d == StDone);
    end
  end

  assign AddressSelect = addr_q;
  assign mStart        = mstart_q;
  assign bufferRD      = bufrd_q;
  assign Add           = add_q;
  assign direct        = direct_q;
  assign done          = done_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: a command table plus reset corner sequences.
module tb_matrix_operand_loader;
  import matrix_pkg::*;

  localparam int unsigned LaneW = DefLaneW;
  localparam int unsigned RowW  = DefRowW;
  localparam int unsigned AddrW = DefAddressLength;

  logic             Clk = 1'b0;
  logic             Rst, cmd_valid, cmd_add, cmd_direct, s_valid;
  logic [AddrW:0]   cmd_rows;
  logic [LaneW-1:0] s_data;
  logic             cmd_ready, s_ready, mStart, bufferRD, Add, direct, done;
  logic [RowW-1:0]  multiplier_input, multiplicand_input;
  logic [AddrW-1:0] AddressSelect;

  matrix_operand_loader dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_rows           (cmd_rows),
    .cmd_add            (cmd_add),
    .cmd_direct         (cmd_direct),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_data             (s_data),
    .multiplier_input   (multiplier_input),
    .multiplicand_input (multiplicand_input),
    .AddressSelect      (AddressSelect),
    .mStart             (mStart),
    .bufferRD           (bufferRD),
    .Add                (Add),
    .direct             (direct),
    .done               (done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rows;
    logic        add;
    logic        dir;
    bit          stall;
    bit          poke;
    int          exp_n;
    logic [63:0] exp_mult;
    logic [63:0] exp_mcand;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input int idx, input vec_t v);
    int ms_addr[32], ms_cyc[32], rd_addr[32], rd_cyc[32];
    int n_ms, n_rd, n_done, done_cyc, acc_cyc, last_beat_cyc, beat_cyc, beat, total;
    int held_err, sready_err, addr_err, rd_addr_err, gap_err;
    bit hs;
    n_ms = 0; n_rd = 0; n_done = 0; done_cyc = 0; last_beat_cyc = 0; beat = 0;
    held_err = 0; sready_err = 0; addr_err = 0; rd_addr_err = 0; gap_err = 0;
    total = v.exp_n * 8;

    check($sformatf("v%0d_cmd_ready_idle", idx), cmd_ready, 1);
    cmd_rows   = v.rows;
    cmd_add    = v.add;
    cmd_direct = v.dir;
    cmd_valid  = 1'b1;
    acc_cyc    = cyc;
    step();
    cmd_valid  = 1'b0;
    cmd_add    = ~v.add;
    cmd_direct = ~v.dir;

    for (int g = 0; g < 4000; g++) begin
      if (mStart && n_ms < 32) begin
        ms_addr[n_ms] = int'(AddressSelect);
        ms_cyc[n_ms]  = cyc;
        n_ms++;
      end
      if (bufferRD && n_rd < 32) begin
        rd_addr[n_rd] = int'(AddressSelect);
        rd_cyc[n_rd]  = cyc;
        n_rd++;
      end
      if (Add !== v.add || direct !== v.dir) held_err++;
      if (v.exp_n == 0 && s_ready) sready_err++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        break;
      end
      if (beat < total) begin
        s_valid = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_data  = LaneW'(beat + 1);
      end else begin
        s_valid = (v.exp_n == 0);
        s_data  = 16'hDEAD;
      end
      cmd_valid = v.poke && (beat == 20);
      hs        = s_valid && s_ready;
      beat_cyc  = cyc;
      step();
      if (hs) begin
        beat++;
        last_beat_cyc = beat_cyc;
      end
    end
    s_valid   = 1'b0;
    cmd_valid = 1'b0;

    check($sformatf("v%0d_done_seen", idx), n_done, 1);
    check($sformatf("v%0d_beats_taken", idx), beat, total);
    check($sformatf("v%0d_mstart_count", idx), n_ms, v.exp_n);
    check($sformatf("v%0d_bufferrd_count", idx), n_rd, v.exp_n);
    for (int i = 0; i < n_ms; i++) begin
      if (ms_addr[i] != i) addr_err++;
      if (i > 0 && ms_cyc[i] - ms_cyc[i-1] < 11) gap_err++;
    end
    for (int i = 0; i < n_rd; i++) begin
      if (rd_addr[i] != i) rd_addr_err++;
    end
    check($sformatf("v%0d_issue_addr_errs", idx), addr_err, 0);
    check($sformatf("v%0d_issue_spacing_errs", idx), gap_err, 0);
    check($sformatf("v%0d_read_addr_errs", idx), rd_addr_err, 0);
    check($sformatf("v%0d_flag_hold_errs", idx), held_err, 0);
    check($sformatf("v%0d_sready_idle_errs", idx), sready_err, 0);
    check($sformatf("v%0d_mult_bus", idx), multiplier_input, v.exp_mult);
    check($sformatf("v%0d_mcand_bus", idx), multiplicand_input, v.exp_mcand);
    if (v.exp_n == 0) begin
      check($sformatf("v%0d_done_after_accept", idx), done_cyc - acc_cyc, 1);
    end else if (n_ms > 0 && n_rd > 0) begin
      check($sformatf("v%0d_beat_to_mstart", idx), ms_cyc[n_ms-1] - last_beat_cyc, 1);
      check($sformatf("v%0d_issue_to_read", idx), rd_cyc[0] - ms_cyc[n_ms-1], DefIssueGap);
      check($sformatf("v%0d_read_contiguous", idx), rd_cyc[n_rd-1] - rd_cyc[0], n_rd - 1);
      check($sformatf("v%0d_read_to_done", idx), done_cyc - rd_cyc[n_rd-1], 1);
    end
    step();
    check($sformatf("v%0d_done_one_cycle", idx), done, 0);
    check($sformatf("v%0d_back_to_idle", idx), cmd_ready, 1);
  endtask

  initial begin
    int beat, n_bad;
    bit hs;

    vecs[0] = '{5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1,
                64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
    vecs[1] = '{5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 3,
                64'h0014_0013_0012_0011, 64'h0018_0017_0016_0015};
    vecs[2] = '{5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 0,
                64'h0014_0013_0012_0011, 64'h0018_0017_0016_0015};
    vecs[3] = '{5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 16,
                64'h007C_007B_007A_0079, 64'h0080_007F_007E_007D};
    vecs[4] = '{5'd17, 1'b0, 1'b0, 1'b1, 1'b0, 16,
                64'h007C_007B_007A_0079, 64'h0080_007F_007E_007D};

    Rst = 1'b1; cmd_valid = 1'b0; cmd_add = 1'b0; cmd_direct = 1'b0;
    cmd_rows = '0; s_valid = 1'b0; s_data = '0;
    step();
    step();
    Rst = 1'b0;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_strobes", {mStart, bufferRD, done, Add, direct, s_ready}, 0);
    check("reset_addr", AddressSelect, 0);
    check("reset_mult", multiplier_input, 0);
    check("reset_mcand", multiplicand_input, 0);

    for (int i = 0; i < 5; i++) run_cmd(i, vecs[i]);

    // Reset in the middle of the multiplicand fill.
    cmd_rows = 5'd1; cmd_add = 1'b1; cmd_direct = 1'b1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    beat = 0;
    for (int g = 0; g < 100 && beat < 6; g++) begin
      s_valid = 1'b1;
      s_data  = LaneW'(16'hA000 + beat);
      hs      = s_valid && s_ready;
      step();
      if (hs) beat++;
    end
    check("midrst_beats_taken", beat, 6);
    check("midrst_mult_loaded", multiplier_input, 64'hA003_A002_A001_A000);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_strobes", {mStart, bufferRD, done, Add, direct, s_ready}, 0);
    check("midrst_mult", multiplier_input, 0);
    check("midrst_mcand", multiplicand_input, 0);
    n_bad = 0;
    for (int g = 0; g < 20; g++) begin
      if (mStart || done || s_ready || bufferRD) n_bad++;
      step();
    end
    s_valid = 1'b0;
    check("midrst_quiet_after", n_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream feeder for matrixAccelerator. Accepts a serial element stream over a valid/ready handshake and packs each row into the flat multiplier_input and multiplicand_input buses. For each row it drives AddressSelect and mStart, spacing rows by a fixed issue gap. After the last row it walks the result buffer with bufferRD so the downstream stage can read flatsumout.

## Interface
Parameters:
- BIT_LENGTH, 8, base width; one lane is LANE_W = 2*BIT_LENGTH bits
- INPUT_PORT_COUNT, 4, lanes per operand row
- ADDRESS_LENGTH, 4, row address width; max rows = 2**ADDRESS_LENGTH
- ISSUE_GAP, 4, cycles from one mStart pulse to the next fill start (≥1)

Ports:
- Clk  in  1  single clock; all state on rising edge
- Rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  start request
- cmd_ready  out  1  high only in IDLE
- cmd_rows  in  ADDRESS_LENGTH+1  rows to process, 0..2**ADDRESS_LENGTH
- cmd_add  in  1  latched at command accept, drives Add
- cmd_direct  in  1  latched at command accept, drives direct
- s_valid  in  1  element valid
- s_ready  out  1  element accepted when s_valid & s_ready
- s_data  in  LANE_W  element
- multiplier_input  out  INPUT_PORT_COUNT*LANE_W  packed multiplier row
- multiplicand_input  out  INPUT_PORT_COUNT*LANE_W  packed multiplicand row
- AddressSelect  out  ADDRESS_LENGTH  row address
- mStart  out  1  one-cycle row issue strobe
- bufferRD  out  1  result buffer read strobe
- Add  out  1  registered cmd_add
- direct  out  1  registered cmd_direct
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FILL_A, FILL_B, ISSUE, GAP, READ, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_rows, cmd_add and cmd_direct, and clear row=0.
  - Next state is FILL_A if cmd_rows≠0, else DONE.
- FILL_A:
  - s_ready=1.
  - Beat k (0..INPUT_PORT_COUNT-1) writes multiplier_input lane k, bits [k*LANE_W +: LANE_W].
  - After beat INPUT_PORT_COUNT-1, go to FILL_B.
- FILL_B: same as FILL_A, but writes multiplicand_input; then go to ISSUE.
- ISSUE:
  - One cycle with mStart=1 and AddressSelect=row.
  - Both operand buses are fully loaded during this cycle.
  - Next state is GAP.
- GAP:
  - Counter runs ISSUE_GAP-1 cycles, mStart=0.
  - Then row++. If row==cmd_rows go to READ, else go to FILL_A.
- READ:
  - bufferRD=1 for cmd_rows consecutive cycles.
  - AddressSelect steps 0,1,…,cmd_rows-1, one per cycle.
- DONE: done=1 for one cycle, then IDLE.
- Operand registers hold their value until overwritten lane-by-lane by the next fill. They are not cleared between rows or commands.
- Add and direct stay constant from command accept until the next accept.
- s_ready=0 outside the FILL states. Beats offered then are not consumed.
- cmd_valid outside IDLE is ignored, since cmd_ready=0.
- cmd_rows > 2**ADDRESS_LENGTH is clamped to 2**ADDRESS_LENGTH at accept.

## Timing
- Reset values: every output 0, except cmd_ready=1. State is IDLE, counters are 0.
- Rst mid-operation: next cycle returns to the reset values. The partial row is discarded and no done is issued.
- Throughput per row: 2*INPUT_PORT_COUNT accepted beats, plus 1 ISSUE cycle, plus ISSUE_GAP-1 GAP cycles.
- s_valid gaps stall the fill with no timeout. Lane index advances only on a handshake.
- Latency from the last beat of row r to mStart: 1 cycle (ISSUE follows the FILL_B final beat).
- Latency from the last GAP cycle to the first bufferRD: 1 cycle.
- Latency from the last bufferRD to done: 1 cycle.
- cmd_rows=0: accept cycle, then DONE, so done is high 1 cycle after accept. No mStart and no bufferRD.
- Row counter wrap: with cmd_rows=2**ADDRESS_LENGTH, AddressSelect uses the low ADDRESS_LENGTH bits of the row. The row counter itself is ADDRESS_LENGTH+1 bits, so the termination compare is exact.
- All outputs are registered. There is no combinational path from inputs to outputs, except s_ready and cmd_ready, which decode from state.

## Structure
- Shared package matrix_pkg holds:
  - The state enum.
  - The LANE_W derivation.
  - Flat bus width constants, kept consistent with the BIT_LENGTH, INPUT_PORT_COUNT and ADDRESS_LENGTH values in definitions.h.
- Sub-module operand_row_packer:
  - Lane counter plus a lane-write decoder for one INPUT_PORT_COUNT*LANE_W register.
  - Instantiated twice, for multiplier and multiplicand.
  - Outputs a row_full pulse to the top FSM.
- Top level contains the FSM, the row/gap/read counters and the cmd latches.

## Test plan
Run with defaults: LANE_W=16, 4 lanes, ISSUE_GAP=4.
- Reset: hold Rst for 2 cycles, then release. All outputs 0, cmd_ready=1. Assert Rst mid-FILL_B: next cycle state is IDLE, mStart and done never pulse.
- Single row: cmd_rows=1, beats 0x0001..0x0008 with no stalls.
  - multiplier_input=0x0004_0003_0002_0001 and multiplicand_input=0x0008_0007_0006_0005.
  - mStart pulses exactly once with AddressSelect=0, one cycle after beat 8.
  - bufferRD is high 1 cycle with AddressSelect=0, then done is high 1 cycle.
- Multi-row with stalls: cmd_rows=3, random s_valid gaps.
  - Three mStart pulses with AddressSelect 0,1,2.
  - Each pulse is at least 3+8 cycles apart.
  - bufferRD is high 3 consecutive cycles with addresses 0,1,2.
- Zero rows: cmd_rows=0. done pulses 1 cycle after accept; mStart and bufferRD stay 0; s_ready stays 0.
- Full depth and flags: cmd_rows=16, cmd_add=1, cmd_direct=0.
  - AddressSelect runs 0..15 with no wrap to 0 before completion.
  - Add=1 and direct=0 are held throughout.
  - cmd_valid pulsed mid-run is ignored (no restart).
- Clamp: cmd_rows=17 processes 16 rows exactly.
